sub_mp_seq: RTL and testbench
=============================

SUB_MP_SEQ -- requirements
Module: sub_mp_seq

Interface
REQ-001 Parameter NLIMBS, default 4, is the number of 64-bit limbs per operand; legal range 2..16.
REQ-002 Parameter LIMB_W, default 64, is the limb width; only 64 is supported.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair on din1/din2 is presented.
REQ-006 in_ready  output  1  block accepts an operand pair this cycle.
REQ-007 din1  input  NLIMBS*64  minuend, unsigned, limb 0 = bits [63:0].
REQ-008 din2  input  NLIMBS*64  subtrahend, unsigned.
REQ-009 out_valid  output  1  result on dout/bout/zero is valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 dout  output  NLIMBS*64  din1 - din2, modulo 2^(NLIMBS*64).
REQ-012 bout  output  1  final borrow; 1 when din1 < din2.
REQ-013 zero  output  1  1 when dout is all zeros.
REQ-014 busy  output  1  1 in RUN or DONE.

Function
REQ-015 FSM states: IDLE, RUN, DONE. Reset state: IDLE.
REQ-016 in_ready = 1 in IDLE, and in DONE when out_ready = 1; otherwise 0.
REQ-017 Accept (in_valid & in_ready): latch din1/din2, clear limb index and borrow register, enter RUN.
REQ-018 RUN processes limb[idx] once per cycle: {b, d} = A[idx] - B[idx] - borrow (65-bit result). d goes to result limb idx; borrow <= b; idx increments.
REQ-019 RUN -> DONE on the cycle that processes idx = NLIMBS-1.
REQ-020 Latency: if accept occurs at edge T, out_valid is 1 from edge T+NLIMBS.
REQ-021 In DONE, out_valid = 1. dout, bout and zero hold stable until out_valid & out_ready.
REQ-022 DONE with out_ready = 1 and in_valid = 0 -> IDLE.
REQ-023 DONE with out_ready = 1 and in_valid = 1 -> accept the new pair and enter RUN in the same cycle (back-to-back).
REQ-024 out_valid = 0 in IDLE and RUN. dout is not guaranteed except in DONE.
REQ-025 zero is computed from the stored result at entry to DONE and is registered.
REQ-026 in_valid in RUN is ignored. Operands are not re-sampled; din1/din2 may change after accept.
REQ-027 Arithmetic wraps modulo 2^(NLIMBS*64). No saturation.

Reset
REQ-028 rst = 1 at any edge: state <= IDLE, idx <= 0, borrow <= 0, out_valid <= 0, bout <= 0, zero <= 0, dout <= 0, busy <= 0.
REQ-029 rst in RUN or DONE abandons the operation. No result is emitted.
REQ-030 rst dominates any handshake in the same cycle.
REQ-031 in_ready = 1 on the first cycle after rst deasserts.

Structure
REQ-032 Shared package sub_pkg holds LIMB_W, the FSM state enum type, and the limb-index width function clog2(NLIMBS).
REQ-033 One sub-module, sub_limb_64: combinational 64-bit subtract with borrow-in and borrow-out. It is instantiated once and reused across cycles.
REQ-034 Operand storage is shift registers: one limb is consumed per cycle from the LSB end. The result is shifted in from the MSB end.

Verification (NLIMBS = 4)
REQ-035 din1 = 0, din2 = 1 -> dout = all ones (256 bits), bout = 1, zero = 0, out_valid at T+4.
REQ-036 din1 = 2^64, din2 = 1 -> dout limb0 = 0xFFFF_FFFF_FFFF_FFFF, limbs 1..3 = 0, bout = 0; checks borrow propagation across limbs.
REQ-037 din1 = din2 = 0xDEAD...BEEF (random 256-bit) -> dout = 0, zero = 1, bout = 0.
REQ-038 out_ready held 0 for 6 cycles in DONE -> out_valid stays 1, dout/bout/zero stable, in_ready = 0.
REQ-039 Two pairs with in_valid held high and out_ready = 1 -> second accept in the DONE cycle of the first; results 5 cycles apart in order.
REQ-040 rst pulsed at edge T+2 of a RUN -> out_valid never asserts for that operation; in_ready = 1 at T+3; next operation completes correctly.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the sequential multi-precision subtractor: the limb
// width, the control FSM state type and the limb-index width helper.
package sub_pkg;

    localparam int LIMB_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= n; sizes the limb index for NLIMBS limbs.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sub_limb_64.sv
// One 64-bit limb of the subtractor: d = a - b - bin, with borrow-out.
module sub_limb_64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        bin,
    output logic [63:0] d,
    output logic        bout
);

    // The 65th bit of the widened difference goes to 1 exactly when the
    // true result is negative, which is the borrow-out.
    assign {bout, d} = {1'b0, a} - {1'b0, b} - {64'd0, bin};

endmodule

// File: rtl/sub_mp_seq.sv
// Sequential NLIMBS x 64-bit subtractor: one limb per cycle through a single
// sub_limb_64, operands shifted out from the LSB end, result shifted in at the MSB.
module sub_mp_seq #(
    parameter int NLIMBS = 4,
    parameter int LIMB_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NLIMBS*LIMB_W-1:0] din1,
    input  logic [NLIMBS*LIMB_W-1:0] din2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NLIMBS*LIMB_W-1:0] dout,
    output logic                     bout,
    output logic                     zero,
    output logic                     busy
);

    import sub_pkg::*;

    localparam int W     = NLIMBS * LIMB_W;
    localparam int IDX_W = clog2(NLIMBS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             borrow;
    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [LIMB_W-1:0] limb_d;
    logic             limb_b;
    logic [W-1:0]     res_next;
    logic             accept;

    sub_limb_64 u_limb (
        .a    (a_sr[LIMB_W-1:0]),
        .b    (b_sr[LIMB_W-1:0]),
        .bin  (borrow),
        .d    (limb_d),
        .bout (limb_b)
    );

    // dout doubles as the result shift register; it only holds a meaningful
    // value in DONE, which is the only time out_valid is raised.
    assign res_next = {limb_d, dout[W-1:LIMB_W]};

    assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    // NOTE: operand shift registers carry no reset; they are always reloaded
    // on accept before being read, so resetting them only costs logic.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sr <= din1;
            b_sr <= din2;
        end else if (state == ST_RUN) begin
            a_sr <= a_sr >> LIMB_W;
            b_sr <= b_sr >> LIMB_W;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others, whatever the statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            borrow    <= 1'b0;
            out_valid <= 1'b0;
            bout      <= 1'b0;
            zero      <= 1'b0;
            dout      <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    dout   <= res_next;
                    borrow <= limb_b;
                    idx    <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        bout      <= limb_b;
                        zero      <= (res_next == '0);
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: next pair starts while this result leaves.
                            idx    <= '0;
                            borrow <= 1'b0;
                            state  <= ST_RUN;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_mp_seq.sv
// Self-checking bench for sub_mp_seq (NLIMBS = 4): scoreboard of expected
// results computed with full-width arithmetic, popped as results appear.
module tb_sub_mp_seq;

    localparam int NLIMBS = 4;
    localparam int W      = NLIMBS * 64;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] dout;
    logic         bout;
    logic         zero;
    logic         busy;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sub_mp_seq #(.NLIMBS(NLIMBS), .LIMB_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din1      (din1),
        .din2      (din2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .bout      (bout),
        .zero      (zero),
        .busy      (busy)
    );

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d = a - b;
        e.b = (a < b);
        e.z = (a == b);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One operation from an idle/consumable state: checks run-state flags,
    // latency and result against the scoreboard head.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   cyc;
        int   acc_cyc;
        bit   acc;
        bit   acc_seen;
        bit   done;
        in_valid = 1'b1;
        din1     = a;
        din2     = b;
        sb.push_back(model(a, b));
        acc_seen = 1'b0;
        done     = 1'b0;
        cyc      = 0;
        acc_cyc  = 0;
        while (!done && cyc < 40) begin
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc && !acc_seen) begin
                acc_seen = 1'b1;
                acc_cyc  = cyc;
                in_valid = 1'b0;
                din1     = rand_w();
                din2     = rand_w();
                n_tests++;
                if (busy !== 1'b1 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s run_flags: busy=%b out_valid=%b, required busy=1 out_valid=0",
                             name, busy, out_valid);
                end
            end else if (acc_seen && out_valid === 1'b1) begin
                done = 1'b1;
                e = sb.pop_front();
                n_tests++;
                if (cyc - acc_cyc !== NLIMBS) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d edges, required %0d", name, cyc - acc_cyc, NLIMBS);
                end
                n_tests++;
                if (dout !== e.d) begin
                    n_fail++;
                    $display("FAIL %s dout: got %h required %h", name, dout, e.d);
                end
                n_tests++;
                if (bout !== e.b || zero !== e.z) begin
                    n_fail++;
                    $display("FAIL %s flags: bout=%b zero=%b, required bout=%b zero=%b",
                             name, bout, zero, e.b, e.z);
                end
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no result within 40 cycles (accepted=%0b)", name, acc_seen);
            sb.delete();
            in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        din1      = '0;
        din2      = '0;
        repeat (3) step();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        n_tests++;
        if (dout !== '0 || bout !== 1'b0 || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: dout=%h bout=%b zero=%b, required all 0", dout, bout, zero);
        end
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] a;
        logic [W-1:0] v;
        run_op("zero_minus_one", '0, W'(1));
        a = '0;
        a[64] = 1'b1;
        run_op("borrow_chain", a, W'(1));
        v = rand_w();
        v[W-1 -: 32] = 32'hDEAD_BEEF;
        v[31:0]      = 32'hDEAD_BEEF;
        run_op("equal_operands", v, v);
        run_op("a_max_minus_max", '1, '1);
        for (int i = 0; i < 4; i++) run_op("random", rand_w(), rand_w());
        step();
        n_tests++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_ops: busy=%b in_ready=%b out_valid=%b, required 0 1 0",
                     busy, in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        bit           bad;
        a = rand_w();
        b = rand_w();
        e = model(a, b);
        out_ready = 1'b0;
        run_op("bp_first", a, b);
        in_valid = 1'b1;
        din1     = rand_w();
        din2     = rand_w();
        bad      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || dout !== e.d || bout !== e.b || zero !== e.z)
                bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold: out_valid=%b in_ready=%b dout=%h, required 1 0 %h",
                     out_valid, in_ready, dout, e.d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2;
        exp_t e;
        int   cyc;
        int   n_acc;
        int   n_res;
        int   acc_cyc[2];
        int   res_cyc[2];
        bit   acc;
        a1 = rand_w();
        b1 = rand_w();
        a2 = rand_w();
        b2 = a2 + W'(3);
        sb.push_back(model(a1, b1));
        sb.push_back(model(a2, b2));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        din1      = a1;
        din2      = b1;
        cyc       = 0;
        n_acc     = 0;
        n_res     = 0;
        acc_cyc   = '{0, 0};
        res_cyc   = '{0, 0};
        while (n_res < 2 && cyc < 40) begin
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (out_valid === 1'b1) begin
                e = sb.pop_front();
                res_cyc[n_res] = cyc;
                n_res++;
                n_tests++;
                if (dout !== e.d || bout !== e.b || zero !== e.z) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d: dout=%h bout=%b zero=%b, required %h %b %b",
                             n_res, dout, bout, zero, e.d, e.b, e.z);
                end
            end
            if (acc && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 1) begin
                    din1 = a2;
                    din2 = b2;
                end else begin
                    in_valid = 1'b0;
                    din1     = rand_w();
                    din2     = rand_w();
                end
            end
        end
        n_tests++;
        if (n_res != 2) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0d results, required 2", n_res);
            sb.delete();
            in_valid = 1'b0;
        end else begin
            n_tests++;
            if (res_cyc[0] - acc_cyc[0] !== NLIMBS || res_cyc[1] - res_cyc[0] !== NLIMBS + 1) begin
                n_fail++;
                $display("FAIL b2b_spacing: first latency %0d gap %0d, required %0d and %0d",
                         res_cyc[0] - acc_cyc[0], res_cyc[1] - res_cyc[0], NLIMBS, NLIMBS + 1);
            end
            n_tests++;
            if (acc_cyc[1] !== res_cyc[0] + 1) begin
                n_fail++;
                $display("FAIL b2b_accept: second accept at %0d, required %0d", acc_cyc[1], res_cyc[0] + 1);
            end
        end
        step();
    endtask

    task automatic test_reset_abort();
        bit seen;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        din1     = rand_w();
        din2     = rand_w();
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_rst: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        step();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_in_ready: got %b required 1", in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL abort_no_result: out_valid asserted, required never");
        end
        run_op("after_abort", rand_w(), rand_w());
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
